// File: rtl/mem_arb_pkg.sv
// rtl/mem_arb_pkg.sv - shared types and helpers for the IF/MEM memory port arbiter
package mem_arb_pkg;

  localparam int ARB_STATE_W = 2;

  typedef enum logic [ARB_STATE_W-1:0] {
    ARB_IDLE = 2'd0,
    ARB_BUSY = 2'd1,
    ARB_RESP = 2'd2
  } arb_state_t;

  typedef enum logic {
    OWN_IF = 1'b0,
    OWN_D  = 1'b1
  } arb_owner_t;

  // Streak counter width: enough to hold max_streak, never narrower than 3 bits.
  function automatic int streak_cnt_w(input int max_streak);
    int w;
    w = $clog2(max_streak + 1);
    return (w < 3) ? 3 : w;
  endfunction

endpackage

// File: rtl/mem_port_arbiter_if.sv
// rtl/mem_port_arbiter_if.sv - fetch, data and memory-side handshake bundle for the arbiter
interface mem_port_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) ();

  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic              if_kill;
  logic              if_rvalid;
  logic [DATA_W-1:0] if_rdata;
  logic              if_stall;

  logic              d_req;
  logic              d_we;
  logic [ADDR_W-1:0] d_addr;
  logic [DATA_W-1:0] d_wdata;
  logic              d_resp;
  logic [DATA_W-1:0] d_rdata;
  logic              d_stall;

  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_ack;
  logic [DATA_W-1:0] mem_rdata;

  // Arbiter side.
  modport slave (
    input  if_req, if_addr, if_kill, d_req, d_we, d_addr, d_wdata, mem_ack, mem_rdata,
    output if_rvalid, if_rdata, if_stall, d_resp, d_rdata, d_stall,
    output mem_req, mem_we, mem_addr, mem_wdata
  );

  // Pipeline stages plus memory model.
  modport master (
    output if_req, if_addr, if_kill, d_req, d_we, d_addr, d_wdata, mem_ack, mem_rdata,
    input  if_rvalid, if_rdata, if_stall, d_resp, d_rdata, d_stall,
    input  mem_req, mem_we, mem_addr, mem_wdata
  );

endinterface

// File: rtl/arb_streak_counter.sv
// rtl/arb_streak_counter.sv - saturating count of consecutive contended data grants
module arb_streak_counter
  import mem_arb_pkg::*;
#(
  parameter int MAX_STREAK = 4,
  localparam int CNT_W = streak_cnt_w(MAX_STREAK)
) (
  input  logic clk,
  input  logic reset,
  input  logic clr_i,
  input  logic inc_i,
  output logic at_max_o
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (inc_i && (cnt_q != CNT_W'(MAX_STREAK))) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign at_max_o = (cnt_q == CNT_W'(MAX_STREAK));

endmodule

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - serialises fetch and data requests onto one memory port
// Optional FETCH_FAIRNESS_EN forces a fetch grant after MAX_D_STREAK contended data grants.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W       = 32,
  parameter int DATA_W       = 32,
  parameter int MAX_D_STREAK = 4
) (
  input logic               clk,
  input logic               reset,
  mem_port_arbiter_if.slave arb
);

  arb_state_t        state_q, state_d;
  arb_owner_t        owner_q, owner_d;
  logic              drop_q, drop_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
  logic [DATA_W-1:0] d_rdata_q, d_rdata_d;

  logic fetch_ok;
  logic force_if;
  logic grant_d;
  logic grant_if;
  logic if_rvalid;
  logic d_resp;

  assign fetch_ok = arb.if_req & ~arb.if_kill;

`ifdef FETCH_FAIRNESS_EN
  logic streak_at_max;

  arb_streak_counter #(
    .MAX_STREAK (MAX_D_STREAK)
  ) u_streak (
    .clk      (clk),
    .reset    (reset),
    .clr_i    (grant_if | (grant_d & ~arb.if_req)),
    .inc_i    (grant_d & arb.if_req),
    .at_max_o (streak_at_max)
  );

  assign force_if = streak_at_max & fetch_ok;
`else
  assign force_if = 1'b0;
`endif

  assign grant_d  = (state_q == ARB_IDLE) & arb.d_req & ~force_if;
  assign grant_if = (state_q == ARB_IDLE) & fetch_ok & ~grant_d;

  always_comb begin
    state_d    = state_q;
    owner_d    = owner_q;
    drop_d     = drop_q;
    we_d       = we_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    if_rdata_d = if_rdata_q;
    d_rdata_d  = d_rdata_q;
    unique case (state_q)
      ARB_IDLE: begin
        if (grant_d) begin
          owner_d = OWN_D;
          we_d    = arb.d_we;
          addr_d  = arb.d_addr;
          wdata_d = arb.d_wdata;
          state_d = ARB_BUSY;
        end else if (grant_if) begin
          owner_d = OWN_IF;
          we_d    = 1'b0;
          addr_d  = arb.if_addr;
          state_d = ARB_BUSY;
        end
      end
      ARB_BUSY: begin
        // A killed fetch still runs to completion; only its response is dropped.
        if ((owner_q == OWN_IF) && arb.if_kill) begin
          drop_d = 1'b1;
        end
        if (arb.mem_ack) begin
          state_d = ARB_RESP;
          if (owner_q == OWN_IF) begin
            if_rdata_d = arb.mem_rdata;
          end else if (!we_q) begin
            d_rdata_d = arb.mem_rdata;
          end
        end
      end
      ARB_RESP: begin
        state_d = ARB_IDLE;
        drop_d  = 1'b0;
      end
      default: begin
        state_d = ARB_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q    <= ARB_IDLE;
      owner_q    <= OWN_IF;
      drop_q     <= 1'b0;
      we_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      if_rdata_q <= '0;
      d_rdata_q  <= '0;
    end else begin
      state_q    <= state_d;
      owner_q    <= owner_d;
      drop_q     <= drop_d;
      we_q       <= we_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      if_rdata_q <= if_rdata_d;
      d_rdata_q  <= d_rdata_d;
    end
  end

  assign if_rvalid = (state_q == ARB_RESP) & (owner_q == OWN_IF) & ~drop_q & ~arb.if_kill;
  assign d_resp    = (state_q == ARB_RESP) & (owner_q == OWN_D);

  assign arb.mem_req   = (state_q == ARB_BUSY);
  assign arb.mem_we    = (state_q == ARB_BUSY) & we_q;
  assign arb.mem_addr  = addr_q;
  assign arb.mem_wdata = wdata_q;

  assign arb.if_rvalid = if_rvalid;
  assign arb.if_rdata  = if_rdata_q;
  assign arb.if_stall  = arb.if_req & ~if_rvalid;
  assign arb.d_resp    = d_resp;
  assign arb.d_rdata   = d_rdata_q;
  assign arb.d_stall   = arb.d_req & ~d_resp;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - self-checking bench for mem_port_arbiter with a transaction-level model
module tb_mem_port_arbiter;

  localparam int AW   = 32;
  localparam int DW   = 32;
  localparam int MAXS = 4;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  mem_port_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

  mem_port_arbiter #(
    .ADDR_W       (AW),
    .DATA_W       (DW),
    .MAX_D_STREAK (MAXS)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .arb   (bus)
  );

  int n_checks = 0;
  int n_errs   = 0;
  bit chk_en   = 0;

  // Stimulus applied at the next negedge.
  logic        s_reset, s_if_req, s_if_kill, s_d_req, s_d_we, s_mem_ack;
  logic [31:0] s_if_addr, s_d_addr, s_d_wdata, s_mem_rdata;

  // Model: the memory port is either free, carrying one transaction, or returning its response.
  bit          m_busy, m_resp, m_own_d, m_drop, m_we;
  logic [31:0] m_addr, m_wdata, m_if_rdata, m_d_rdata;
  int          m_streak;
  int          grant_log[$];
  logic [31:0] mem [int unsigned];
  bit          x_if_rvalid, x_d_resp;

  function automatic logic [31:0] mem_read(input logic [31:0] a);
    if (mem.exists(a)) return mem[a];
    return a ^ 32'h5A5A_0000;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errs++;
      $display("FAIL %s actual=0x%0h expected=0x%0h t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic idle_inputs();
    s_reset = 1; s_if_req = 0; s_if_kill = 0; s_d_req = 0; s_d_we = 0; s_mem_ack = 0;
    s_if_addr = 0; s_d_addr = 0; s_d_wdata = 0; s_mem_rdata = 0;
  endtask

  task automatic tick();
    bit e_ifv, e_dr, fair, pick_if;
    @(negedge clk);
    reset         = s_reset;
    bus.if_req    = s_if_req;
    bus.if_addr   = s_if_addr;
    bus.if_kill   = s_if_kill;
    bus.d_req     = s_d_req;
    bus.d_we      = s_d_we;
    bus.d_addr    = s_d_addr;
    bus.d_wdata   = s_d_wdata;
    bus.mem_ack   = s_mem_ack;
    bus.mem_rdata = s_mem_rdata;
    #1;
    e_ifv = m_resp && !m_own_d && !m_drop && !s_if_kill;
    e_dr  = m_resp && m_own_d;
    x_if_rvalid = e_ifv;
    x_d_resp    = e_dr;
    if (chk_en) begin
      chk("mem_req", bus.mem_req, m_busy);
      if (m_busy) begin
        chk("mem_we", bus.mem_we, m_we);
        chk("mem_addr", bus.mem_addr, m_addr);
        if (m_we) chk("mem_wdata", bus.mem_wdata, m_wdata);
      end
      chk("if_rvalid", bus.if_rvalid, e_ifv);
      chk("d_resp", bus.d_resp, e_dr);
      chk("if_stall", bus.if_stall, s_if_req && !e_ifv);
      chk("d_stall", bus.d_stall, s_d_req && !e_dr);
      chk("d_rdata", bus.d_rdata, m_d_rdata);
      if (e_ifv) chk("if_rdata", bus.if_rdata, m_if_rdata);
    end
    if (!s_reset) begin
      m_busy = 0; m_resp = 0; m_drop = 0; m_own_d = 0; m_we = 0;
      m_addr = 0; m_wdata = 0; m_if_rdata = 0; m_d_rdata = 0; m_streak = 0;
    end else if (m_resp) begin
      m_resp = 0;
      m_drop = 0;
    end else if (m_busy) begin
      if (!m_own_d && s_if_kill) m_drop = 1;
      if (s_mem_ack) begin
        m_busy = 0;
        m_resp = 1;
        if (m_own_d && m_we) mem[m_addr] = m_wdata;
        else if (m_own_d) m_d_rdata = s_mem_rdata;
        else m_if_rdata = s_mem_rdata;
      end
    end else begin
      fair = 0;
`ifdef FETCH_FAIRNESS_EN
      fair = (m_streak == MAXS);
`endif
      pick_if = s_if_req && !s_if_kill && (!s_d_req || fair);
      if (pick_if) begin
        m_busy = 1; m_own_d = 0; m_we = 0; m_addr = s_if_addr; m_streak = 0;
        grant_log.push_back(0);
      end else if (s_d_req) begin
        m_busy = 1; m_own_d = 1; m_we = s_d_we; m_addr = s_d_addr; m_wdata = s_d_wdata;
        m_streak = s_if_req ? ((m_streak < MAXS) ? m_streak + 1 : MAXS) : 0;
        grant_log.push_back(1);
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    int stall_cnt;
    int base;
    int exp_own;
    bit f_act, d_act;

    // Reset and idle outputs.
    idle_inputs();
    s_reset = 0;
    tick(); tick();
    s_reset = 1; chk_en = 1;
    tick();
    chk("rst_mem_req", bus.mem_req, 0);
    chk("rst_mem_we", bus.mem_we, 0);
    chk("rst_mem_addr", bus.mem_addr, 0);
    chk("rst_mem_wdata", bus.mem_wdata, 0);
    chk("rst_if_rvalid", bus.if_rvalid, 0);
    chk("rst_d_resp", bus.d_resp, 0);
    chk("rst_d_rdata", bus.d_rdata, 0);

    // Fetch @0x0, ack three cycles after mem_req.
    s_if_req = 1; s_if_addr = 32'h0; stall_cnt = 0;
    for (int c = 0; c < 5; c++) begin
      s_mem_ack   = (c == 4);
      s_mem_rdata = (c == 4) ? 32'h0050_0093 : 32'h0;
      tick();
      stall_cnt += int'(bus.if_stall);
      if (c == 0) chk("f0_mem_req_c0", bus.mem_req, 0);
      if (c == 1) chk("f0_mem_req_c1", bus.mem_req, 1);
      if (c < 4) chk("f0_no_rvalid", bus.if_rvalid, 0);
    end
    s_mem_ack = 0;
    tick();
    chk("f0_rvalid", bus.if_rvalid, 1);
    chk("f0_rdata", bus.if_rdata, 32'h0050_0093);
    chk("f0_stall_low", bus.if_stall, 0);
    chk("f0_stall_cycles", stall_cnt, 5);
    s_if_req = 0;
    tick();
    chk("f0_rvalid_single", bus.if_rvalid, 0);

    // Simultaneous fetch and load: data first.
    s_if_req = 1; s_if_addr = 32'h40; s_d_req = 1; s_d_we = 0; s_d_addr = 32'h1000;
    tick();
    s_mem_ack = 1; s_mem_rdata = 32'h1234_5678;
    tick();
    chk("pri_first_addr", bus.mem_addr, 32'h1000);
    s_mem_ack = 0;
    tick();
    chk("pri_d_resp", bus.d_resp, 1);
    chk("pri_d_rdata", bus.d_rdata, 32'h1234_5678);
    chk("pri_no_if_yet", bus.if_rvalid, 0);
    s_d_req = 0;
    tick();
    chk("pri_no_reaccept", bus.mem_req, 0);
    s_mem_ack = 1; s_mem_rdata = 32'hCAFE_F00D;
    tick();
    chk("pri_second_addr", bus.mem_addr, 32'h40);
    s_mem_ack = 0;
    tick();
    chk("pri_if_rvalid", bus.if_rvalid, 1);
    chk("pri_if_rdata", bus.if_rdata, 32'hCAFE_F00D);
    s_if_req = 0;
    tick();

    // Store: write held until ack, load data register untouched.
    s_d_req = 1; s_d_we = 1; s_d_addr = 32'h2000; s_d_wdata = 32'hDEAD_BEEF;
    tick();
    for (int c = 0; c < 3; c++) begin
      s_mem_ack = (c == 2);
      tick();
      chk("st_mem_we", bus.mem_we, 1);
      chk("st_mem_wdata", bus.mem_wdata, 32'hDEAD_BEEF);
      chk("st_mem_addr", bus.mem_addr, 32'h2000);
    end
    s_mem_ack = 0;
    tick();
    chk("st_d_resp", bus.d_resp, 1);
    chk("st_d_rdata_held", bus.d_rdata, 32'h1234_5678);
    s_d_req = 0; s_d_we = 0;
    tick();
    chk("st_d_resp_single", bus.d_resp, 0);

    // Kill: blocks acceptance in IDLE, suppresses response in BUSY.
    s_if_req = 1; s_if_addr = 32'h80; s_if_kill = 1;
    tick();
    s_if_kill = 0;
    tick();
    chk("kill_idle_blocked", bus.mem_req, 0);
    tick();
    chk("kill_busy_addr", bus.mem_addr, 32'h80);
    s_if_kill = 1;
    tick();
    s_if_kill = 0; s_if_req = 0; s_mem_ack = 1; s_mem_rdata = 32'h1111_1111;
    tick();
    chk("kill_txn_runs", bus.mem_req, 1);
    s_mem_ack = 0;
    tick();
    chk("kill_no_rvalid", bus.if_rvalid, 0);
    s_if_req = 1; s_if_addr = 32'h200;
    tick();
    s_mem_ack = 1; s_mem_rdata = 32'h2222_2222;
    tick();
    chk("kill_next_addr", bus.mem_addr, 32'h200);
    s_mem_ack = 0;
    tick();
    chk("kill_next_rvalid", bus.if_rvalid, 1);
    chk("kill_next_rdata", bus.if_rdata, 32'h2222_2222);
    s_if_req = 0;
    tick();

    // Reset mid-BUSY abandons the transaction.
    s_d_req = 1; s_d_we = 0; s_d_addr = 32'h3000;
    tick(); tick();
    chk("rb_busy", bus.mem_req, 1);
    s_reset = 0; s_d_req = 0;
    tick(); tick();
    s_reset = 1; s_if_req = 1; s_if_addr = 32'h100;
    tick();
    chk("rb_mem_req", bus.mem_req, 0);
    chk("rb_d_resp", bus.d_resp, 0);
    chk("rb_if_rvalid", bus.if_rvalid, 0);
    tick();
    chk("rb_fetch_req", bus.mem_req, 1);
    chk("rb_fetch_addr", bus.mem_addr, 32'h100);
    s_mem_ack = 1; s_mem_rdata = 32'h3333_3333;
    tick();
    s_mem_ack = 0;
    tick();
    chk("rb_fetch_rvalid", bus.if_rvalid, 1);
    s_if_req = 0;
    tick();

    // Both requesters held continuously.
    base = grant_log.size();
    s_d_req = 1; s_d_we = 0; s_d_addr = 32'h3000; s_if_req = 1; s_if_addr = 32'h300;
    for (int c = 0; c < 200 && grant_log.size() < base + 10; c++) begin
      s_mem_ack = m_busy; s_mem_rdata = mem_read(m_addr);
      tick();
    end
    chk("fair_grant_count", grant_log.size() >= base + 10, 1);
    for (int i = 0; i < 10; i++) begin
      exp_own = 1;
`ifdef FETCH_FAIRNESS_EN
      exp_own = (i % 5 == 4) ? 0 : 1;
`endif
      if (base + i < grant_log.size())
        chk($sformatf("fair_grant%0d", i), grant_log[base + i], exp_own);
    end
    s_d_req = 0; s_if_req = 0;
    for (int c = 0; c < 10 && (m_busy || m_resp); c++) begin
      s_mem_ack = m_busy; s_mem_rdata = mem_read(m_addr);
      tick();
    end
    s_mem_ack = 0;
    tick();

    // Randomized traffic.
    f_act = 0; d_act = 0;
    for (int c = 0; c < 3000; c++) begin
      if (!f_act && $urandom_range(0, 3) == 0) begin
        f_act = 1; s_if_addr = {22'h0, 8'($urandom_range(0, 255)), 2'b00};
      end
      if (!d_act && $urandom_range(0, 2) == 0) begin
        d_act = 1; s_d_we = 1'($urandom_range(0, 1));
        s_d_addr = 32'h1000 + 32'(4 * $urandom_range(0, 7)); s_d_wdata = $urandom;
      end
      s_if_req  = f_act;
      s_d_req   = d_act;
      s_if_kill = f_act ? ($urandom_range(0, 15) == 0) : ($urandom_range(0, 31) == 0);
      if (m_busy) begin
        s_mem_ack   = ($urandom_range(0, 2) == 0);
        s_mem_rdata = m_we ? $urandom : mem_read(m_addr);
      end else begin
        s_mem_ack   = ($urandom_range(0, 7) == 0);
        s_mem_rdata = $urandom;
      end
      s_reset = ($urandom_range(0, 499) != 0);
      tick();
      if (x_if_rvalid || s_if_kill) f_act = 0;
      if (x_d_resp) d_act = 0;
      if (!s_reset) begin f_act = 0; d_act = 0; end
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errs);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one single-ported unified memory between the pipelined CPU's instruction-fetch (IF) port and its data (MEM-stage) port.
- Sits between the IF/MEM stages and the memory model. Serialises requests with a 3-state FSM and a held-request/response protocol.
- Generates per-port stall signals the pipeline uses in place of the old dual-port memory timing.
- Supports fetch cancellation on branch misprediction.

Parameters:
ADDR_W, 32, address width
DATA_W, 32, data width
MAX_D_STREAK, 4, consecutive contended data grants before fetch is forced (used only with FETCH_FAIRNESS_EN)

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-low reset (asserted when 0, sampled on rising edge of clk)
if_req  in  1  fetch request; held with if_addr until if_rvalid or if_kill
if_addr  in  ADDR_W  fetch address
if_kill  in  1  cancel in-flight/pending fetch (misprediction flush)
if_rvalid  out  1  one-cycle fetch response pulse
if_rdata  out  DATA_W  fetched instruction, valid with if_rvalid
if_stall  out  1  if_req & ~if_rvalid
d_req  in  1  data request; held with d_we/d_addr/d_wdata until d_resp
d_we  in  1  1 = store, 0 = load
d_addr  in  ADDR_W  data address
d_wdata  in  DATA_W  store data
d_resp  out  1  one-cycle completion pulse (load or store)
d_rdata  out  DATA_W  load data, valid with d_resp
d_stall  out  1  d_req & ~d_resp
mem_req  out  1  memory request, held until mem_ack
mem_we  out  1  memory write enable
mem_addr  out  ADDR_W  memory address
mem_wdata  out  DATA_W  memory write data
mem_ack  in  1  memory completion; mem_rdata valid same cycle
mem_rdata  in  DATA_W  memory read data

Behaviour:
- States: IDLE, BUSY, RESP. Owner register: IF or D.
- IDLE:
  - If d_req, latch d_we/d_addr/d_wdata, set owner=D, go to BUSY.
  - Else if if_req & ~if_kill, latch if_addr with we=0, set owner=IF, go to BUSY.
  - Else stay in IDLE.
  - Data has strict priority over fetch.
- BUSY:
  - mem_req=1; mem_we/mem_addr/mem_wdata driven from the latched registers and stable until mem_ack.
  - On mem_ack: capture mem_rdata into the owner's rdata register, go to RESP.
  - No timeout.
- RESP (exactly 1 cycle):
  - owner=D: d_resp=1.
  - owner=IF: if_rvalid = ~drop & ~if_kill.
  - Always go to IDLE. No acceptance occurs in RESP, so a still-high req from the requester just served is never re-accepted.
- Latency:
  - Request in IDLE at cycle 0 gives mem_req at cycle 1.
  - mem_ack at cycle k≥1 gives the response pulse at k+1.
  - Next acceptance earliest at k+2.
- Kill handling:
  - drop flag is set by if_kill while owner=IF in BUSY; cleared on entering IDLE.
  - The memory transaction still completes; only the response is suppressed.
  - if_kill in IDLE blocks fetch acceptance that cycle.
- d_rdata is updated only on load completion; it holds its value on stores. if_rdata is updated only on fetch completion.
- mem_ack outside BUSY is ignored.
- Reset (reset=0), in any state:
  - Next cycle: IDLE, owner=IF, drop=0, fairness counter=0, rdata registers=0.
  - Outputs: mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0, if_rvalid=0, d_resp=0.
  - if_stall/d_stall remain combinational from req.
  - An in-flight transaction is abandoned; the memory model must tolerate mem_req dropping.

Optional Feature:
- Macro: FETCH_FAIRNESS_EN.
- With the macro defined:
  - 3-bit-minimum streak counter (width $clog2(MAX_D_STREAK+1)).
  - Increments on each D grant made while if_req=1 (saturating at MAX_D_STREAK).
  - Clears on any IF grant, or on a D grant with if_req=0.
  - When counter==MAX_D_STREAK and both requests are present in IDLE, IF is granted.
- Without the macro: strict data priority; no counter logic is instantiated.

Decomposition:
- Package mem_arb_pkg holds:
  - arb_state_t enum {ARB_IDLE, ARB_BUSY, ARB_RESP}
  - arb_owner_t enum {OWN_IF, OWN_D}
  - localparam ARB_STATE_W=2
- One natural sub-module: arb_streak_counter (saturating counter with clear/inc/at_max). Instantiated only under FETCH_FAIRNESS_EN.

Test Plan:
- Reset=0 for 2 cycles mid-BUSY with mem_req=1 → next cycle mem_req=0, if_rvalid=0, d_resp=0, state IDLE; reset=1 then if_req@0x100 → mem_req cycle+1.
- if_req@0x0, mem_ack 3 cycles after mem_req with mem_rdata=0x00500093 → if_rvalid single pulse with if_rdata=0x00500093, if_stall high until that cycle.
- if_req@0x40 and d_req load@0x1000 in same IDLE cycle → mem_addr=0x1000 first, d_resp/d_rdata first, then mem_addr=0x40.
- Store d_we=1 addr 0x2000 wdata 0xDEADBEEF → mem_we=1, mem_wdata=0xDEADBEEF held until mem_ack; d_resp pulse; d_rdata unchanged.
- Fetch@0x80 in BUSY, if_kill pulse → mem transaction completes, no if_rvalid; next fetch@0x200 served normally.
- FETCH_FAIRNESS_EN, MAX_D_STREAK=4, d_req and if_req held high continuously → 4 D grants, then 1 IF grant, counter cleared; without the macro, IF is never granted.
